// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types and tap/lockup helpers for the LFSR random source
//
// Purpose: maximal-length tap masks for widths 3..16, lockup-value helper,
//          and the bounded-request FSM state type.
// Ports:   none (package).
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    HOLD = 2'd2
  } rng_state_t;

  // Bit i set means state bit i feeds the feedback XOR/XNOR.
  // Each mask gives period 2^width-1 for the shift-left Fibonacci form.
  function automatic logic [15:0] tap_mask(input int width);
    logic [15:0] m;
    case (width)
      3:       m = 16'h0006;
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

  // XNOR feedback locks up at all-ones, XOR feedback at all-zeros.
  function automatic logic [15:0] lockup(input int width, input int xnor_fb);
    logic [15:0] ones;
    ones = 16'hFFFF >> (16 - width);
    return (xnor_fb != 0) ? ones : 16'h0000;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - Fibonacci LFSR state register with step, load and lockup substitution
//
// Purpose: holds the LFSR state; load beats step; seeds equal to the lockup
//          value are replaced by lockup ^ 1 so the state never locks up.
// Ports:
//   clk, reset   clock, synchronous active-high reset (state <= SEED)
//   step         advance one LFSR step this cycle
//   load         write seed_in (substituted) this cycle
//   seed_in      seed value for load
//   state        current registered state
//   fb           feedback bit of the current state (next state's bit 0)
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int          WIDTH = 10,
  parameter int          XNOR  = 1,
  parameter int unsigned SEED  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state,
  output logic             fb
);

  localparam logic [15:0]      MASK16   = tap_mask(WIDTH);
  localparam logic [15:0]      LOCK16   = lockup(WIDTH, XNOR);
  localparam logic [WIDTH-1:0] MASK     = MASK16[WIDTH-1:0];
  localparam logic [WIDTH-1:0] LOCKUP   = LOCK16[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] SEED_RST = (SEED_W == LOCKUP) ? (SEED_W ^ WIDTH'(1)) : SEED_W;

  logic [WIDTH-1:0] state_q, state_d;

  function automatic logic [WIDTH-1:0] substitute(input logic [WIDTH-1:0] s);
    return (s == LOCKUP) ? (s ^ WIDTH'(1)) : s;
  endfunction

  always_comb begin
    fb = ^(state_q & MASK);
    if (XNOR != 0) begin
      fb = ~fb;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = substitute(seed_in);
    end else if (step) begin
      state_d = {state_q[WIDTH-2:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEED_RST;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_rng.sv
// rtl/lfsr_rng.sv - LFSR random source with a bounded-value valid/ready port
//
// Purpose: free-running LFSR plus a request port returning a value in
//          [MIN, MIN+RANGE-1] by rejection sampling, falling back to
//          cand-RANGE after MAX_TRIES rejected draws.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   en           free-running step enable
//   load         load seed_in; aborts a pending request
//   seed_in      seed for load
//   lfsr_out     registered LFSR state
//   req          request a bounded value (sampled in IDLE only)
//   rand_valid   rand_data valid, held until accepted
//   rand_ready   consumer accepts rand_data
//   rand_data    bounded random value
module lfsr_rng
  import lfsr_pkg::*;
#(
  parameter int          WIDTH     = 10,
  parameter int          XNOR      = 1,
  parameter int unsigned SEED      = 0,
  parameter int          RANGE     = 5,
  parameter int          MIN       = 40,
  parameter int          DW        = 10,
  parameter int          MAX_TRIES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] lfsr_out,
  input  logic             req,
  output logic             rand_valid,
  input  logic             rand_ready,
  output logic [DW-1:0]    rand_data
);

  localparam int               RBITS    = $clog2(RANGE);
  localparam int               TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
  localparam logic [RBITS:0]   RANGE_C  = (RBITS + 1)'(RANGE);
  localparam logic [DW-1:0]    RANGE_DW = DW'(RANGE);
  localparam logic [DW-1:0]    MIN_DW   = DW'(MIN);

  if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
    $error("lfsr_rng: WIDTH must be 3..16");
  end
  if (RANGE < 2 || longint'(RANGE) > (longint'(1) << WIDTH)) begin : g_bad_range
    $error("lfsr_rng: RANGE must be 2..2^WIDTH");
  end
  if (MAX_TRIES < 1) begin : g_bad_tries
    $error("lfsr_rng: MAX_TRIES must be at least 1");
  end
  if (longint'(SEED) >= (longint'(1) << WIDTH)) begin : g_bad_seed
    $error("lfsr_rng: SEED wider than WIDTH");
  end
  if ((longint'(MIN) + longint'(RANGE) - 1) >= (longint'(1) << DW)) begin : g_bad_dw
    $error("lfsr_rng: MIN+RANGE-1 does not fit in DW");
  end

  rng_state_t       fsm_q, fsm_d;
  logic [TRY_W-1:0] try_q, try_d;
  logic             rand_valid_q, rand_valid_d;
  logic [DW-1:0]    rand_data_q, rand_data_d;

  logic             lfsr_fb;
  logic             step;
  logic [RBITS-1:0] cand;
  logic [DW-1:0]    cand_dw;
  logic             cand_ok;
  logic             abort;

  // DRAW always steps so every try sees a fresh state.
  assign step = en | (fsm_q == DRAW);

  lfsr_core #(
    .WIDTH (WIDTH),
    .XNOR  (XNOR),
    .SEED  (SEED)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .step    (step),
    .load    (load),
    .seed_in (seed_in),
    .state   (lfsr_out),
    .fb      (lfsr_fb)
  );

  // Candidate is the low RBITS of the state being stepped into this edge.
  if (RBITS == 1) begin : g_cand1
    assign cand = lfsr_fb;
  end else begin : g_candn
    assign cand = {lfsr_out[RBITS-2:0], lfsr_fb};
  end

  assign cand_dw = DW'(cand);
  assign cand_ok = ({1'b0, cand} < RANGE_C);
  assign abort   = load && (fsm_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q        <= IDLE;
      try_q        <= '0;
      rand_valid_q <= 1'b0;
      rand_data_q  <= '0;
    end else begin
      fsm_q        <= fsm_d;
      try_q        <= try_d;
      rand_valid_q <= rand_valid_d;
      rand_data_q  <= rand_data_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    try_d = try_q;
    case (fsm_q)
      IDLE: begin
        if (req) begin
          fsm_d = DRAW;
          try_d = '0;
        end
      end
      DRAW: begin
        if (cand_ok || (try_q == LAST_TRY)) begin
          fsm_d = HOLD;
        end else begin
          try_d = try_q + TRY_W'(1);
        end
      end
      HOLD: begin
        if (rand_valid_q && rand_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
    if (abort) begin
      fsm_d = IDLE;
    end
  end

  // Fallback subtraction is exact in DW bits: a rejected cand is below 2*RANGE.
  always_comb begin
    rand_valid_d = rand_valid_q;
    rand_data_d  = rand_data_q;
    if (abort) begin
      rand_valid_d = 1'b0;
    end else begin
      case (fsm_q)
        DRAW: begin
          if (cand_ok) begin
            rand_valid_d = 1'b1;
            rand_data_d  = cand_dw + MIN_DW;
          end else if (try_q == LAST_TRY) begin
            rand_valid_d = 1'b1;
            rand_data_d  = cand_dw - RANGE_DW + MIN_DW;
          end
        end
        HOLD: begin
          if (rand_valid_q && rand_ready) begin
            rand_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rand_valid = rand_valid_q;
  assign rand_data  = rand_data_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// tb/tb_lfsr_rng.sv - self-checking bench for lfsr_rng with default parameters
module tb_lfsr_rng;

  localparam int WIDTH = 10;
  localparam int RANGE = 5;
  localparam int MIN   = 40;
  localparam int DW    = 10;
  localparam int TRIES = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] seed_in = '0;
  logic [WIDTH-1:0] lfsr_out;
  logic             req = 1'b0;
  logic             rand_valid;
  logic             rand_ready = 1'b0;
  logic [DW-1:0]    rand_data;

  int n_cmp = 0;
  int n_fail = 0;

  lfsr_rng #(
    .WIDTH(WIDTH), .XNOR(1), .SEED(0), .RANGE(RANGE),
    .MIN(MIN), .DW(DW), .MAX_TRIES(TRIES)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in),
    .lfsr_out(lfsr_out), .req(req), .rand_valid(rand_valid),
    .rand_ready(rand_ready), .rand_data(rand_data)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Reference: 10-bit XNOR LFSR with taps 9 and 6, shifted left.
  function automatic int m_step(input int s);
    int fb;
    fb = 1 - (((s >> 9) & 1) ^ ((s >> 6) & 1));
    return ((s << 1) & 1023) | fb;
  endfunction

  function automatic int m_seed(input int s);
    return (s == 1023) ? 1022 : s;
  endfunction

  // Whole request outcome: number of draws, value returned, final state.
  task automatic m_draw(input int s0, output int k, output int val, output int s_end);
    int s, c;
    s = s0;
    k = 0;
    val = 0;
    for (int t = 1; t <= TRIES; t++) begin
      s = m_step(s);
      c = s % 8;
      k = t;
      if (c < RANGE) begin
        val = c + MIN;
        break;
      end
      if (t == TRIES) val = c - RANGE + MIN;
    end
    s_end = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; load = 1'b0; req = 1'b0; rand_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    req = 1'b1; tick(); req = 1'b0; tick();
    en = 1'b1; tick(); tick();
    do_reset();
    n_cmp++;
    if (lfsr_out !== 10'h000) begin
      n_fail++; $display("FAIL reset_lfsr: got %h expected 000", lfsr_out);
    end
    n_cmp++;
    if (rand_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", rand_valid);
    end
    n_cmp++;
    if (rand_data !== 10'd0) begin
      n_fail++; $display("FAIL reset_data: got %0d expected 0", rand_data);
    end
  endtask

  task automatic test_sequence();
    logic [WIDTH-1:0] exp_seq [9];
    exp_seq = '{10'h000, 10'h001, 10'h003, 10'h007, 10'h00F,
                10'h01F, 10'h03F, 10'h07F, 10'h0FE};
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (lfsr_out !== exp_seq[i]) begin
        n_fail++; $display("FAIL seq_step%0d: got %h expected %h", i, lfsr_out, exp_seq[i]);
      end
      if (i < 8) tick();
    end
    en = 1'b0;
  endtask

  task automatic test_period();
    bit seen [1024];
    int s, distinct, bad;
    do_reset();
    foreach (seen[i]) seen[i] = 1'b0;
    seen[0] = 1'b1;
    distinct = 1;
    bad = 0;
    s = 0;
    en = 1'b1;
    for (int st = 1; st <= 1023; st++) begin
      tick();
      s = m_step(s);
      n_cmp++;
      if (int'(lfsr_out) !== s) begin
        n_fail++; $display("FAIL period_step%0d: got %h expected %h", st, lfsr_out, s);
      end
      if (st < 1023) begin
        if (lfsr_out == 10'h3FF) bad++;
        if (!seen[lfsr_out]) distinct++;
        seen[lfsr_out] = 1'b1;
      end
    end
    en = 1'b0;
    n_cmp++;
    if (lfsr_out !== 10'h000) begin
      n_fail++; $display("FAIL period_wrap: got %h expected 000", lfsr_out);
    end
    n_cmp++;
    if (distinct !== 1023) begin
      n_fail++; $display("FAIL period_distinct: got %0d expected 1023", distinct);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL period_lockup_seen: got %0d expected 0", bad);
    end
  endtask

  task automatic test_load();
    do_reset();
    load = 1'b1; seed_in = 10'h3FF; tick(); load = 1'b0;
    n_cmp++;
    if (lfsr_out !== 10'h3FE) begin
      n_fail++; $display("FAIL load_lockup: got %h expected 3FE", lfsr_out);
    end
    load = 1'b1; en = 1'b1; seed_in = 10'h005; tick(); load = 1'b0; en = 1'b0;
    n_cmp++;
    if (lfsr_out !== 10'h005) begin
      n_fail++; $display("FAIL load_wins: got %h expected 005", lfsr_out);
    end
  endtask

  task automatic test_req_basic();
    do_reset();
    req = 1'b1; tick(); req = 1'b0;
    n_cmp++;
    if (rand_valid !== 1'b0) begin
      n_fail++; $display("FAIL req_early_valid: got %b expected 0", rand_valid);
    end
    tick();
    n_cmp++;
    if (rand_valid !== 1'b1 || rand_data !== 10'd41) begin
      n_fail++; $display("FAIL req_first: got v=%b d=%0d expected v=1 d=41", rand_valid, rand_data);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (rand_valid !== 1'b1 || rand_data !== 10'd41) begin
        n_fail++; $display("FAIL req_hold%0d: got v=%b d=%0d expected v=1 d=41", i, rand_valid, rand_data);
      end
    end
    rand_ready = 1'b1; tick(); rand_ready = 1'b0;
    n_cmp++;
    if (rand_valid !== 1'b0) begin
      n_fail++; $display("FAIL req_accept: got v=%b expected 0", rand_valid);
    end
  endtask

  task automatic test_fallback();
    do_reset();
    load = 1'b1; seed_in = 10'h003; tick(); load = 1'b0;
    req = 1'b1; tick(); req = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++;
      if (rand_valid !== 1'b0) begin
        n_fail++; $display("FAIL fallback_early%0d: got v=%b expected 0", i, rand_valid);
      end
    end
    tick();
    n_cmp++;
    if (rand_valid !== 1'b1 || rand_data !== 10'd42) begin
      n_fail++; $display("FAIL fallback_value: got v=%b d=%0d expected v=1 d=42", rand_valid, rand_data);
    end
    n_cmp++;
    if (lfsr_out !== 10'h03F) begin
      n_fail++; $display("FAIL fallback_state: got %h expected 03F", lfsr_out);
    end
    rand_ready = 1'b1; tick(); rand_ready = 1'b0;
  endtask

  task automatic test_abort();
    do_reset();
    load = 1'b1; seed_in = 10'h003; tick(); load = 1'b0;
    req = 1'b1; tick(); req = 1'b0;
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n_cmp++;
    if (rand_valid !== 1'b0 || lfsr_out !== 10'h000) begin
      n_fail++; $display("FAIL abort_reset: got v=%b s=%h expected v=0 s=000", rand_valid, lfsr_out);
    end
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if (rand_valid !== 1'b0 || lfsr_out !== 10'h000) begin
      n_fail++; $display("FAIL abort_reset_idle: got v=%b s=%h expected v=0 s=000", rand_valid, lfsr_out);
    end
    req = 1'b1; tick(); req = 1'b0; tick();
    n_cmp++;
    if (rand_valid !== 1'b1 || rand_data !== 10'd41) begin
      n_fail++; $display("FAIL abort_pre_hold: got v=%b d=%0d expected v=1 d=41", rand_valid, rand_data);
    end
    load = 1'b1; seed_in = 10'h155; tick(); load = 1'b0;
    n_cmp++;
    if (rand_valid !== 1'b0 || lfsr_out !== 10'h155) begin
      n_fail++; $display("FAIL abort_load: got v=%b s=%h expected v=0 s=155", rand_valid, lfsr_out);
    end
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (rand_valid !== 1'b0 || lfsr_out !== 10'h155) begin
      n_fail++; $display("FAIL abort_load_idle: got v=%b s=%h expected v=0 s=155", rand_valid, lfsr_out);
    end
  endtask

  task automatic test_random();
    int s, seed, k, val, s_end, cyc, h;
    do_reset();
    s = 0;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        seed = ($urandom_range(0, 4) == 0) ? 1023 : int'($urandom_range(0, 1023));
        en = 1'($urandom_range(0, 1));
        load = 1'b1; seed_in = WIDTH'(seed); tick(); load = 1'b0;
        s = m_seed(seed);
        n_cmp++;
        if (int'(lfsr_out) !== s) begin
          n_fail++; $display("FAIL rnd_load%0d: got %h expected %h", it, lfsr_out, s);
        end
      end
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
        en = 1'($urandom_range(0, 1));
        tick();
        if (en) s = m_step(s);
      end
      en = 1'($urandom_range(0, 1));
      req = 1'b1; tick(); req = 1'b0;
      if (en) s = m_step(s);
      m_draw(s, k, val, s_end);
      cyc = 0;
      while (rand_valid !== 1'b1 && cyc < 10) begin
        en = 1'($urandom_range(0, 1));
        tick();
        cyc++;
      end
      s = s_end;
      n_cmp++;
      if (cyc !== k || int'(rand_data) !== val || int'(lfsr_out) !== s) begin
        n_fail++;
        $display("FAIL rnd_req%0d: got lat=%0d d=%0d s=%h expected lat=%0d d=%0d s=%h",
                 it, cyc, rand_data, lfsr_out, k, val, s);
      end
      rand_ready = 1'b0;
      h = $urandom_range(0, 3);
      for (int i = 0; i < h; i++) begin
        en = 1'($urandom_range(0, 1));
        req = 1'($urandom_range(0, 1));
        tick();
        req = 1'b0;
        if (en) s = m_step(s);
        n_cmp++;
        if (rand_valid !== 1'b1 || int'(rand_data) !== val) begin
          n_fail++; $display("FAIL rnd_hold%0d: got v=%b d=%0d expected v=1 d=%0d", it, rand_valid, rand_data, val);
        end
      end
      en = 1'($urandom_range(0, 1));
      rand_ready = 1'b1; tick(); rand_ready = 1'b0;
      if (en) s = m_step(s);
      n_cmp++;
      if (rand_valid !== 1'b0 || int'(lfsr_out) !== s) begin
        n_fail++; $display("FAIL rnd_accept%0d: got v=%b s=%h expected v=0 s=%h", it, rand_valid, lfsr_out, s);
      end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_period();
    test_load();
    test_req_basic();
    test_fallback();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
